// File: rtl/fmc_slave.sv
// fmc_slave: STM32F FMC (NOR/SRAM, 16-bit, NWAIT) async slave that pairs two halfword
// phases into one 32-bit request/ack command. Optional ack timeout: FMC_SLAVE_ACK_TIMEOUT_EN.
module fmc_slave #(
    parameter real         SYS_CLK_T_SECS       = 9.23e-9,
    parameter real         STM32F_HCLK_T_SECS   = 62.5e-9,
    parameter int unsigned FMC_ADDR_SETUP_HCLKS = 15,
    parameter int unsigned FMC_DATA_SETUP_HCLKS = 15,
    parameter int unsigned FMC_BUS_TURN_HCLKS   = 15,
    parameter int unsigned ACK_TIMEOUT_CLKS     = 1024
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst,
    input  logic        i_cmd_ack,
    input  logic [31:0] i_cmd_rdata,
    output logic        o_cmd_sel,
    output logic        o_cmd_rd_wr_n,
    output logic [25:0] o_cmd_byte_addr,
    output logic [31:0] o_cmd_wdata,
    input  logic [24:0] i_fmc_a,
    input  logic [15:0] i_fmc_d,
    output logic [15:0] o_fmc_d,
    output logic        o_fmc_d_high_z,
    input  logic        i_fmc_ne1,
    input  logic        i_fmc_noe,
    input  logic        i_fmc_nwe,
    output logic        o_fmc_nwait
);

    localparam int unsigned FMC_AW = 25;
    localparam int unsigned FMC_DW = 16;
    localparam int unsigned CMD_AW = 26;
    localparam int unsigned CMD_DW = 32;
    localparam int unsigned CTL_W  = 3;

    localparam real NWAIT_BUDGET_SECS =
        real'(FMC_ADDR_SETUP_HCLKS + FMC_DATA_SETUP_HCLKS) * STM32F_HCLK_T_SECS
        - 2.0 * STM32F_HCLK_T_SECS;
    localparam real BUS_RELEASE_SECS =
        real'(FMC_BUS_TURN_HCLKS + 1) * STM32F_HCLK_T_SECS;

    // NWAIT must reach the MCU before its data phase ends; D must float before bus turnaround ends.
    if (3.0 * SYS_CLK_T_SECS >= NWAIT_BUDGET_SECS) begin : g_nwait_chk
        $error("fmc_slave: NWAIT cannot be asserted before the FMC data phase ends");
    end
    if (3.0 * SYS_CLK_T_SECS >= BUS_RELEASE_SECS) begin : g_turn_chk
        $error("fmc_slave: D release slower than FMC bus turnaround");
    end
    if (ACK_TIMEOUT_CLKS < 1) begin : g_tmo_chk
        $error("fmc_slave: ACK_TIMEOUT_CLKS must be at least 1");
    end

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_LO,
        ST_WR_WAIT_HI,
        ST_WR_CMD,
        ST_WR_DONE,
        ST_RD_CMD,
        ST_RD_LO,
        ST_RD_WAIT_HI,
        ST_RD_HI
    } state_e;

    // Two-flop synchronisers for every FMC pin; control bits packed as {ne1, noe, nwe}
    logic [CTL_W-1:0]  ctl_meta_q, ctl_sync_q;
    logic [FMC_AW-1:0] a_meta_q, a_sync_q;
    logic [FMC_DW-1:0] d_meta_q, d_sync_q;
    logic              ne1_s, noe_s, nwe_s;

    assign {ne1_s, noe_s, nwe_s} = ctl_sync_q;

    state_e            state_q, state_d;
    logic              settle_q, settle_d;
    logic              sel_q, sel_d;
    logic              rd_wr_n_q, rd_wr_n_d;
    logic [CMD_AW-1:0] addr_q, addr_d;
    logic [CMD_DW-1:0] wdata_q, wdata_d;
    logic [CMD_DW-1:0] rdata_q, rdata_d;
    logic [FMC_DW-1:0] fmc_d_q, fmc_d_d;
    logic              high_z_q, high_z_d;
    logic              nwait_q, nwait_d;
    logic              tmo_hit;
    logic              rd_driving;

`ifdef FMC_SLAVE_ACK_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT_CLKS + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counts cycles spent waiting for ack; cleared whenever no command is outstanding
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == ST_WR_CMD || state_q == ST_RD_CMD) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    assign tmo_hit = (tmo_cnt_q == TMO_W'(ACK_TIMEOUT_CLKS - 1));

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Next-state and registered-output decode
    always_comb begin
        state_d   = state_q;
        settle_d  = 1'b0;
        sel_d     = sel_q;
        rd_wr_n_d = rd_wr_n_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        fmc_d_d   = fmc_d_q;
        nwait_d   = nwait_q;

        unique case (state_q)
            ST_IDLE: begin
                sel_d   = 1'b0;
                nwait_d = 1'b1;
                if (!ne1_s && !nwe_s && !a_sync_q[0]) begin
                    addr_d  = {a_sync_q, 1'b0};
                    state_d = ST_WR_LO;
                end else if (!ne1_s && !noe_s) begin
                    if (!a_sync_q[0]) begin
                        addr_d    = {a_sync_q, 1'b0};
                        sel_d     = 1'b1;
                        rd_wr_n_d = 1'b1;
                        nwait_d   = 1'b0;
                        state_d   = ST_RD_CMD;
                    end else begin
                        // Stray hi-half read: replay the upper half of the last word read
                        fmc_d_d = rdata_q[31:16];
                        state_d = ST_RD_HI;
                    end
                end
            end

            ST_WR_LO: begin
                if (ne1_s) begin
                    state_d = ST_IDLE;
                end else if (!nwe_s) begin
                    wdata_d[15:0] = d_sync_q;
                end else begin
                    state_d = ST_WR_WAIT_HI;
                end
            end

            ST_WR_WAIT_HI: begin
                if (ne1_s) begin
                    state_d = ST_IDLE;
                end else if (!nwe_s && a_sync_q[0]) begin
                    if (!settle_q) begin
                        settle_d = 1'b1;
                    end else begin
                        wdata_d[31:16] = d_sync_q;
                        sel_d          = 1'b1;
                        rd_wr_n_d      = 1'b0;
                        nwait_d        = 1'b0;
                        state_d        = ST_WR_CMD;
                    end
                end
            end

            ST_WR_CMD: begin
                if (i_cmd_ack || tmo_hit) begin
                    sel_d   = 1'b0;
                    nwait_d = 1'b1;
                    state_d = ST_WR_DONE;
                end
            end

            ST_WR_DONE: begin
                if (nwe_s || ne1_s) begin
                    state_d = ST_IDLE;
                end
            end

            ST_RD_CMD: begin
                if (i_cmd_ack || tmo_hit) begin
                    rdata_d = i_cmd_ack ? i_cmd_rdata : 32'hDEAD_DEAD;
                    fmc_d_d = i_cmd_ack ? i_cmd_rdata[15:0] : 16'hDEAD;
                    sel_d   = 1'b0;
                    nwait_d = 1'b1;
                    state_d = ST_RD_LO;
                end
            end

            ST_RD_LO: begin
                if (ne1_s) begin
                    state_d = ST_IDLE;
                end else if (noe_s) begin
                    state_d = ST_RD_WAIT_HI;
                end else if (a_sync_q[0]) begin
                    fmc_d_d = rdata_q[31:16];
                    state_d = ST_RD_HI;
                end
            end

            ST_RD_WAIT_HI: begin
                if (ne1_s || !nwe_s) begin
                    state_d = ST_IDLE;
                end else if (!noe_s) begin
                    // An even address here is a fresh access; let IDLE decode it
                    if (a_sync_q[0]) begin
                        fmc_d_d = rdata_q[31:16];
                        state_d = ST_RD_HI;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_RD_HI: begin
                if (ne1_s || noe_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rd_driving = (state_d == ST_RD_LO || state_d == ST_RD_HI)
                     && !ne1_s && !noe_s && nwe_s;
        high_z_d   = !rd_driving;
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            ctl_meta_q <= '1;
            ctl_sync_q <= '1;
            a_meta_q   <= '0;
            a_sync_q   <= '0;
            d_meta_q   <= '0;
            d_sync_q   <= '0;
            state_q    <= ST_IDLE;
            settle_q   <= 1'b0;
            sel_q      <= 1'b0;
            rd_wr_n_q  <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            fmc_d_q    <= '0;
            high_z_q   <= 1'b1;
            nwait_q    <= 1'b1;
        end else begin
            ctl_meta_q <= {i_fmc_ne1, i_fmc_noe, i_fmc_nwe};
            ctl_sync_q <= ctl_meta_q;
            a_meta_q   <= i_fmc_a;
            a_sync_q   <= a_meta_q;
            d_meta_q   <= i_fmc_d;
            d_sync_q   <= d_meta_q;
            state_q    <= state_d;
            settle_q   <= settle_d;
            sel_q      <= sel_d;
            rd_wr_n_q  <= rd_wr_n_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            fmc_d_q    <= fmc_d_d;
            high_z_q   <= high_z_d;
            nwait_q    <= nwait_d;
        end
    end

    assign o_cmd_sel       = sel_q;
    assign o_cmd_rd_wr_n   = rd_wr_n_q;
    assign o_cmd_byte_addr = addr_q;
    assign o_cmd_wdata     = wdata_q;
    assign o_fmc_d         = fmc_d_q;
    assign o_fmc_d_high_z  = high_z_q;
    assign o_fmc_nwait     = nwait_q;

endmodule

// File: tb/tb_fmc_slave.sv
// tb_fmc_slave: FMC master model plus echoing command fabric, checked against expectation queues.
`timescale 1ns/1ps
module tb_fmc_slave;

    localparam int unsigned ADDSET_CLKS = 3;
    localparam int unsigned DATA_CLKS   = 8;
    localparam int unsigned GAP_CLKS    = 6;
    localparam int unsigned WAIT_BOUND  = 3000;

    typedef struct packed {
        logic        rd;
        logic [25:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fab_ack, stray_ack;
    logic [31:0] fab_rdata, fab_last;
    logic        sel, rd_wr_n;
    logic [25:0] baddr;
    logic [31:0] wdata;
    logic [24:0] fmc_a;
    logic [15:0] fmc_d_m, fmc_d_s;
    logic        high_z, ne1, noe, nwe, nwait;
    logic        m_drv, fab_mute, sel_prev;
    int unsigned ack_dly;
    int          n_cmp = 0, n_err = 0;
    int          n_exp_cmd = 0, sel_rises = 0, contention = 0;
    cmd_t        exp_cmd_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] tb_last_wr;

    always #5 clk = ~clk;

    fmc_slave dut (
        .i_sys_clk      (clk),
        .i_sys_rst      (rst),
        .i_cmd_ack      (fab_ack | stray_ack),
        .i_cmd_rdata    (fab_rdata),
        .o_cmd_sel      (sel),
        .o_cmd_rd_wr_n  (rd_wr_n),
        .o_cmd_byte_addr(baddr),
        .o_cmd_wdata    (wdata),
        .i_fmc_a        (fmc_a),
        .i_fmc_d        (fmc_d_m),
        .o_fmc_d        (fmc_d_s),
        .o_fmc_d_high_z (high_z),
        .i_fmc_ne1      (ne1),
        .i_fmc_noe      (noe),
        .i_fmc_nwe      (nwe),
        .o_fmc_nwait    (nwait)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_nwait_high(input string tag);
        int unsigned n;
        n = 0;
        while (nwait !== 1'b1 && n < WAIT_BOUND) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_nwait_release"}, 32'(n < WAIT_BOUND), 32'd1);
    endtask

    task automatic fmc_write(input logic [25:0] ba, input logic [31:0] data);
        cmd_t c;
        c.rd = 1'b0; c.addr = ba; c.wdata = data;
        exp_cmd_q.push_back(c);
        n_exp_cmd++;
        tb_last_wr = data;
        @(negedge clk);
        ne1 = 1'b0; fmc_a = ba[25:1]; fmc_d_m = data[15:0]; m_drv = 1'b1;
        repeat (ADDSET_CLKS) @(negedge clk);
        nwe = 1'b0;
        repeat (DATA_CLKS) @(negedge clk);
        nwe = 1'b1;
        repeat (3) @(negedge clk);
        fmc_a = ba[25:1] | 25'd1; fmc_d_m = data[31:16];
        repeat (ADDSET_CLKS) @(negedge clk);
        nwe = 1'b0;
        repeat (DATA_CLKS) @(negedge clk);
        wait_nwait_high("wr");
        nwe = 1'b1;
        @(negedge clk);
        ne1 = 1'b1; m_drv = 1'b0; fmc_d_m = 16'h0;
        repeat (GAP_CLKS) @(negedge clk);
    endtask

    // Lo half only (abort_lo=1) or a lone odd-address halfword: neither may raise a command
    task automatic fmc_write_stray(input logic [25:0] ba, input logic [15:0] data, input logic abort_lo);
        @(negedge clk);
        ne1 = 1'b0; fmc_a = abort_lo ? ba[25:1] : (ba[25:1] | 25'd1); fmc_d_m = data; m_drv = 1'b1;
        repeat (ADDSET_CLKS) @(negedge clk);
        nwe = 1'b0;
        repeat (DATA_CLKS) @(negedge clk);
        chk("stray_wr_nwait", 32'(nwait), 32'd1);
        nwe = 1'b1;
        @(negedge clk);
        ne1 = 1'b1; m_drv = 1'b0; fmc_d_m = 16'h0;
        repeat (GAP_CLKS) @(negedge clk);
        chk("stray_wr_sel", 32'(sel), 32'd0);
    endtask

    task automatic fmc_read(input logic [25:0] ba, input logic [31:0] exp);
        cmd_t        c;
        int unsigned lat;
        logic [15:0] lo, hi;
        logic [31:0] e;
        c.rd = 1'b1; c.addr = ba; c.wdata = 32'h0;
        exp_cmd_q.push_back(c);
        n_exp_cmd++;
        exp_rd_q.push_back(exp);
        @(negedge clk);
        ne1 = 1'b0; fmc_a = ba[25:1];
        repeat (ADDSET_CLKS) @(negedge clk);
        noe = 1'b0;
        lat = 0;
        while (nwait === 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk("rd_nwait_latency", 32'(lat <= 3 && nwait === 1'b0), 32'd1);
        repeat (DATA_CLKS) @(negedge clk);
        wait_nwait_high("rd");
        chk("rd_lo_drive", 32'(high_z), 32'd0);
        lo = fmc_d_s;
        noe = 1'b1;
        repeat (3) @(negedge clk);
        chk("rd_lo_release", 32'(high_z), 32'd1);
        fmc_a = ba[25:1] | 25'd1;
        repeat (ADDSET_CLKS) @(negedge clk);
        noe = 1'b0;
        repeat (DATA_CLKS) @(negedge clk);
        chk("rd_hi_drive", 32'(high_z), 32'd0);
        chk("rd_hi_nwait", 32'(nwait), 32'd1);
        hi = fmc_d_s;
        noe = 1'b1;
        @(negedge clk);
        ne1 = 1'b1;
        e = exp_rd_q.pop_front();
        chk("rd_data", {hi, lo}, e);
        repeat (GAP_CLKS) @(negedge clk);
        chk("rd_end_high_z", 32'(high_z), 32'd1);
    endtask

    task automatic fmc_read_odd(input logic [25:0] ba, input logic [15:0] exp);
        @(negedge clk);
        ne1 = 1'b0; fmc_a = ba[25:1] | 25'd1;
        repeat (ADDSET_CLKS) @(negedge clk);
        noe = 1'b0;
        repeat (DATA_CLKS) @(negedge clk);
        chk("odd_rd_drive", 32'(high_z), 32'd0);
        chk("odd_rd_data", 32'(fmc_d_s), 32'(exp));
        chk("odd_rd_nwait", 32'(nwait), 32'd1);
        noe = 1'b1;
        @(negedge clk);
        ne1 = 1'b1;
        repeat (GAP_CLKS) @(negedge clk);
    endtask

    // Fabric: checks each command against the queue head and acks with the last written word
    initial begin
        cmd_t        e;
        int unsigned n;
        fab_ack = 1'b0; fab_rdata = 32'h0; fab_last = 32'h0;
        forever begin
            @(negedge clk);
            if (sel === 1'b1) begin
                chk("cmd_expected", 32'(exp_cmd_q.size() != 0), 32'd1);
                e = (exp_cmd_q.size() != 0) ? exp_cmd_q.pop_front() : '0;
                chk("cmd_rd_wr_n", 32'(rd_wr_n), 32'(e.rd));
                chk("cmd_addr", 32'(baddr), 32'(e.addr));
                if (!e.rd) begin
                    chk("cmd_wdata", wdata, e.wdata);
                    fab_last = wdata;
                end
                if (fab_mute) begin
                    n = 0;
                    while (sel === 1'b1 && n < WAIT_BOUND) begin
                        @(negedge clk);
                        n++;
                    end
                    chk("tmo_sel_drop", 32'(n >= 1000 && n < WAIT_BOUND), 32'd1);
                    chk("tmo_nwait", 32'(nwait), 32'd1);
                end else begin
                    repeat (ack_dly) @(negedge clk);
                    chk("sel_held", 32'({sel, nwait}), 32'd2);
                    fab_ack = 1'b1; fab_rdata = fab_last;
                    @(negedge clk);
                    fab_ack = 1'b0; fab_rdata = 32'h0;
                    chk("sel_drop", 32'({sel, nwait}), 32'd1);
                end
            end
        end
    end

    initial begin
        sel_prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (sel && !sel_prev) sel_rises++;
                if (m_drv && !high_z) contention++;
            end
            sel_prev = sel;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stray_ack = 1'b0; ack_dly = 0; fab_mute = 1'b0;
        ne1 = 1'b1; noe = 1'b1; nwe = 1'b1; fmc_a = '0; fmc_d_m = '0; m_drv = 1'b0;
        tb_last_wr = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_rd_wr_n", 32'(rd_wr_n), 32'd1);
        chk("rst_addr", 32'(baddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_fmc_d", 32'(fmc_d_s), 32'd0);
        chk("rst_high_z", 32'(high_z), 32'd1);
        chk("rst_nwait", 32'(nwait), 32'd1);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        fmc_write(26'h0, 32'hDEAD_BEEF);
        fmc_write(26'h4, 32'hCAFE_BABE);
        fmc_read(26'h8, tb_last_wr);
        fmc_read(26'hC, tb_last_wr);
        fmc_write(26'h10, 32'hABCD_ABCD);
        fmc_read(26'h14, tb_last_wr);
        fmc_read_odd(26'h16, 16'hABCD);
        fmc_read(26'h18, tb_last_wr);
        fmc_write(26'h1C, 32'hA5A5_A5A5);
        fmc_write_stray(26'h20, 16'h1111, 1'b1);
        fmc_write_stray(26'h22, 16'h2222, 1'b0);

        @(negedge clk) stray_ack = 1'b1;
        @(negedge clk) stray_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("stray_ack_idle", 32'({sel, nwait, high_z}), 32'd3);

        ack_dly = 3;
        fmc_read(26'h24, tb_last_wr);
        fmc_write(26'h28, 32'h1234_5678);
        ack_dly = 0;

`ifdef FMC_SLAVE_ACK_TIMEOUT_EN
        fab_mute = 1'b1;
        fmc_read(26'h2C, 32'hDEAD_DEAD);
        fab_mute = 1'b0;
`endif

        repeat (4) @(negedge clk);
        chk("sel_pulse_count", 32'(sel_rises), 32'(n_exp_cmd));
        chk("cmd_queue_drained", 32'(exp_cmd_q.size()), 32'd0);
        chk("bus_contention", 32'(contention), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
